// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: access sizes, FSM states,
// port-select encoding and the access legality rule.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    RMW_RD,
    RMW_WR
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_e;

  // A half at lane 3 would straddle two words; size 2'b11 has no meaning.
  function automatic logic access_illegal(input logic [1:0] size, input logic [1:0] lane);
    return (size == 2'b11) || ((size == SZ_HALF) && (lane == 2'd3));
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request/response ports plus the memory-side bus of mem_arbiter.
// The slave modport is the arbiter's view; master is the core/memory view.
interface mem_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              if_req_i;
  logic [AWIDTH-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DWIDTH-1:0] if_rdata_o;

  logic              dm_req_i;
  logic              dm_we_i;
  logic [1:0]        dm_size_i;
  logic [AWIDTH-1:0] dm_addr_i;
  logic [DWIDTH-1:0] dm_wdata_i;
  logic              dm_gnt_o;
  logic              dm_rvalid_o;
  logic [DWIDTH-1:0] dm_rdata_o;
  logic              dm_err_o;

  logic [AWIDTH-1:0] mem_addr_o;
  logic [DWIDTH-1:0] mem_wdata_o;
  logic              mem_read_en_o;
  logic              mem_write_en_o;
  logic [DWIDTH-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  dm_req_i, dm_we_i, dm_size_i, dm_addr_i, dm_wdata_i,
    input  mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output dm_gnt_o, dm_rvalid_o, dm_rdata_o, dm_err_o,
    output mem_addr_o, mem_wdata_o, mem_read_en_o, mem_write_en_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output dm_req_i, dm_we_i, dm_size_i, dm_addr_i, dm_wdata_i,
    output mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  dm_gnt_o, dm_rvalid_o, dm_rdata_o, dm_err_o,
    input  mem_addr_o, mem_wdata_o, mem_read_en_o, mem_write_en_o
  );
endinterface

// File: rtl/mem_arb_merge.sv
// Combinational lane merge for sub-word stores: replaces the selected byte
// or halfword of the old word with the right-justified new data.
module mem_arb_merge
  import mem_arb_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  lane,
  input  size_e       size,
  output logic [31:0] merged
);

  logic [4:0]  shift;
  logic [31:0] mask;

  assign shift = {lane, 3'b000};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mask = 32'hFFFF_FFFF;
    case (size)
      SZ_BYTE: mask = 32'h0000_00FF << shift;
      SZ_HALF: mask = 32'h0000_FFFF << shift;
      default: mask = 32'hFFFF_FFFF;
    endcase
  end

  assign merged = (old_word & ~mask) | ((new_data << shift) & mask);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store in front of a
// single-ported word-write memory; sub-word stores run as read-modify-write.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  state_e            state;
  port_e             last_gnt;
  logic [AWIDTH-1:0] rmw_addr;
  logic [1:0]        rmw_lane;
  size_e             rmw_size;
  logic [DWIDTH-1:0] rmw_data;
  logic [DWIDTH-1:0] rmw_word;
  logic [DWIDTH-1:0] merged;

  logic              if_rvalid;
  logic [DWIDTH-1:0] if_rdata;
  logic              dm_rvalid;
  logic [DWIDTH-1:0] dm_rdata;
  logic              dm_err;

  logic if_win;
  logic dm_win;
  logic dm_bad;
  logic dm_sub;
  logic dm_load;

  assign dm_bad  = access_illegal(bus.dm_size_i, bus.dm_addr_i[1:0]);
  assign dm_sub  = bus.dm_we_i && !dm_bad && (bus.dm_size_i != SZ_WORD);
  assign dm_load = !bus.dm_we_i && !dm_bad;

  // On a tie the port that did not win last time is served.
  always_comb begin
    if_win = 1'b0;
    dm_win = 1'b0;
    if (!rst && state == IDLE) begin
      if (bus.if_req_i && (!bus.dm_req_i || last_gnt == PORT_DM)) begin
        if_win = 1'b1;
      end else if (bus.dm_req_i) begin
        dm_win = 1'b1;
      end
    end
  end

  assign bus.if_gnt_o = if_win;
  assign bus.dm_gnt_o = dm_win;

  always_comb begin
    bus.mem_addr_o     = '0;
    bus.mem_wdata_o    = '0;
    bus.mem_read_en_o  = 1'b0;
    bus.mem_write_en_o = 1'b0;
    case (state)
      IDLE: begin
        if (if_win) begin
          bus.mem_addr_o    = bus.if_addr_i;
          bus.mem_read_en_o = 1'b1;
        end else if (dm_win && !dm_bad && !dm_sub) begin
          bus.mem_addr_o = bus.dm_addr_i;
          if (bus.dm_we_i) begin
            bus.mem_write_en_o = 1'b1;
            bus.mem_wdata_o    = bus.dm_wdata_i;
          end else begin
            bus.mem_read_en_o = 1'b1;
          end
        end
      end
      RMW_RD: begin
        bus.mem_addr_o    = rmw_addr;
        bus.mem_read_en_o = 1'b1;
      end
      RMW_WR: begin
        // Gated by rst so an aborted RMW never commits a partial write.
        bus.mem_addr_o     = rmw_addr;
        bus.mem_wdata_o    = rmw_word;
        bus.mem_write_en_o = !rst;
      end
      default: ;
    endcase
  end

  mem_arb_merge u_merge (
    .old_word (bus.mem_rdata_i),
    .new_data (rmw_data),
    .lane     (rmw_lane),
    .size     (rmw_size),
    .merged   (merged)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_gnt  <= PORT_IF;
      rmw_addr  <= '0;
      rmw_lane  <= '0;
      rmw_size  <= SZ_BYTE;
      rmw_data  <= '0;
      rmw_word  <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rvalid <= 1'b0;
      dm_rdata  <= '0;
      dm_err    <= 1'b0;
    end else begin
      if_rvalid <= if_win;
      if_rdata  <= if_win ? bus.mem_rdata_i : '0;
      dm_rvalid <= (dm_win && !dm_sub) || (state == RMW_WR);
      dm_rdata  <= (dm_win && dm_load) ? bus.mem_rdata_i : '0;
      dm_err    <= dm_win && dm_bad;

      if (if_win) begin
        last_gnt <= PORT_IF;
      end else if (dm_win) begin
        last_gnt <= PORT_DM;
      end

      case (state)
        IDLE: begin
          if (dm_win && dm_sub) begin
            rmw_addr <= {bus.dm_addr_i[AWIDTH-1:2], 2'b00};
            rmw_lane <= bus.dm_addr_i[1:0];
            rmw_size <= size_e'(bus.dm_size_i);
            rmw_data <= bus.dm_wdata_i;
            state    <= RMW_RD;
          end
        end
        RMW_RD: begin
          rmw_word <= merged;
          state    <= RMW_WR;
        end
        RMW_WR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_rvalid_o = if_rvalid;
  assign bus.if_rdata_o  = if_rdata;
  assign bus.dm_rvalid_o = dm_rvalid;
  assign bus.dm_rdata_o  = dm_rdata;
  assign bus.dm_err_o    = dm_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a byte-array memory, a transaction
// model (byte-level memory image, round-robin owner, busy window) and random traffic.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  mem_arbiter #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory under the arbiter: 256 bytes, little-endian, combinational read.
  logic [7:0] sim_mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] ma;

  assign ma = bus.mem_addr_o[7:0];
  assign bus.mem_rdata_i = {sim_mem[ma + 8'd3], sim_mem[ma + 8'd2],
                            sim_mem[ma + 8'd1], sim_mem[ma]};

  function automatic logic [7:0] init_byte(input int i);
    if (i == 0) return 8'h13;
    if (i < 4) return 8'h00;
    return 8'(i * 37 + 5);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) sim_mem[i] <= init_byte(i);
    end else if (bus.mem_write_en_o) begin
      for (int k = 0; k < 4; k++) sim_mem[8'(ma + 8'(k))] <= bus.mem_wdata_o[k*8 +: 8];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sim_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {sim_mem[b + 8'd3], sim_mem[b + 8'd2], sim_mem[b + 8'd1], sim_mem[b]};
  endfunction

  // ---------------- reference model ----------------
  port_e ref_last;
  int    ref_busy;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {ref_mem[b + 8'd3], ref_mem[b + 8'd2], ref_mem[b + 8'd1], ref_mem[b]};
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    int n;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int k = 0; k < n; k++) ref_mem[8'(a[7:0] + 8'(k))] = d[k*8 +: 8];
  endtask

  // One transaction round: an optional fetch (raised at cycle if_start) and
  // an optional data access; grants and responses are checked every cycle.
  task automatic issue(input bit do_if, input logic [31:0] ia, input int if_start,
                       input bit do_dm, input bit we, input logic [1:0] sz,
                       input logic [31:0] da, input logic [31:0] wd);
    bit          p_if, p_dm, eg_if, eg_dm, bad_acc, dm_exp_err, done;
    int          if_due, dm_due;
    logic [31:0] if_exp, dm_exp;
    p_if = 1'b0;
    p_dm = do_dm;
    if_due = -1;
    dm_due = -1;
    if_exp = '0;
    dm_exp = '0;
    dm_exp_err = 1'b0;
    done = 1'b0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (do_if && cyc == if_start) p_if = 1'b1;
      bus.if_req_i   = p_if;
      bus.if_addr_i  = ia;
      bus.dm_req_i   = p_dm;
      bus.dm_we_i    = we;
      bus.dm_size_i  = sz;
      bus.dm_addr_i  = da;
      bus.dm_wdata_i = wd;
      @(negedge clk);
      eg_if = p_if && ref_busy == 0 && (!p_dm || ref_last == PORT_DM);
      eg_dm = p_dm && ref_busy == 0 && !eg_if;
      check("if_gnt", bus.if_gnt_o, eg_if);
      check("dm_gnt", bus.dm_gnt_o, eg_dm);
      check("if_rvalid", bus.if_rvalid_o, cyc == if_due);
      if (cyc == if_due) check("if_rdata", bus.if_rdata_o, if_exp);
      check("dm_rvalid", bus.dm_rvalid_o, cyc == dm_due);
      check("dm_err", bus.dm_err_o, (cyc == dm_due) && dm_exp_err);
      if (cyc == dm_due) check("dm_rdata", bus.dm_rdata_o, dm_exp);
      if (ref_busy > 0) ref_busy--;
      if (eg_if) begin
        p_if = 1'b0;
        if_due = cyc + 1;
        if_exp = ref_read(ia);
        ref_last = PORT_IF;
      end
      if (eg_dm) begin
        p_dm = 1'b0;
        dm_due = cyc + 1;
        ref_last = PORT_DM;
        bad_acc = (sz == 2'b11) || (sz == 2'b01 && da[1:0] == 2'd3);
        dm_exp_err = bad_acc;
        dm_exp = '0;
        if (bad_acc) begin
          check("err_bus_quiet", {bus.mem_read_en_o, bus.mem_write_en_o}, 2'b00);
        end else if (!we) begin
          dm_exp = ref_read(da);
        end else begin
          ref_write(da, wd, sz);
          if (sz != 2'b10) begin
            dm_due = cyc + 3;
            ref_busy = 2;
          end
        end
      end
      @(posedge clk); #1;
      if (!p_if && !p_dm && !(do_if && cyc < if_start) &&
          cyc >= if_due && cyc >= dm_due && ref_busy == 0) begin
        done = 1'b1;
        break;
      end
    end
    bus.if_req_i = 1'b0;
    bus.dm_req_i = 1'b0;
    check("txn_done", done, 1'b1);
  endtask

  task automatic check_outputs_idle(input string tag);
    check({tag, "_if_gnt"}, bus.if_gnt_o, 1'b0);
    check({tag, "_dm_gnt"}, bus.dm_gnt_o, 1'b0);
    check({tag, "_if_rvalid"}, bus.if_rvalid_o, 1'b0);
    check({tag, "_dm_rvalid"}, bus.dm_rvalid_o, 1'b0);
    check({tag, "_dm_err"}, bus.dm_err_o, 1'b0);
    check({tag, "_if_rdata"}, bus.if_rdata_o, 32'h0);
    check({tag, "_dm_rdata"}, bus.dm_rdata_o, 32'h0);
    check({tag, "_mem_en"}, {bus.mem_read_en_o, bus.mem_write_en_o}, 2'b00);
  endtask

  localparam logic [31:0] BASE = 32'h0100_0000;

  initial begin
    rst = 1'b1;
    mem_init = 1'b1;
    bus.if_req_i = 1'b1;
    bus.if_addr_i = BASE;
    bus.dm_req_i = 1'b1;
    bus.dm_we_i = 1'b0;
    bus.dm_size_i = 2'b10;
    bus.dm_addr_i = BASE;
    bus.dm_wdata_i = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    ref_last = PORT_IF;
    ref_busy = 0;

    // Reset: requests held high must not be granted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_idle("reset");
    @(posedge clk); #1;
    bus.if_req_i = 1'b0;
    bus.dm_req_i = 1'b0;
    mem_init = 1'b0;
    rst = 1'b0;

    // Lone fetch, then two ties: data wins the first tie, then alternation.
    issue(1, BASE, 0, 0, 0, 2'b10, BASE, 0);
    issue(1, BASE + 32'h4, 0, 1, 0, 2'b10, BASE + 32'h8, 0);
    issue(1, BASE + 32'hC, 0, 1, 0, 2'b10, BASE + 32'h0, 0);

    // Word store then load back.
    issue(0, BASE, 0, 1, 1, 2'b10, BASE + 32'h10, 32'hDEAD_BEEF);
    issue(0, BASE, 0, 1, 0, 2'b10, BASE + 32'h10, 0);

    // Byte RMW with a fetch raised one cycle after the grant.
    issue(0, BASE, 0, 1, 1, 2'b10, BASE + 32'h20, 32'h1122_3344);
    issue(1, BASE + 32'h20, 1, 1, 1, 2'b00, BASE + 32'h22, 32'h0000_00AA);
    check("rmw_merged_word", sim_word(BASE + 32'h20), 32'h11AA_3344);
    issue(0, BASE, 0, 1, 0, 2'b10, BASE + 32'h20, 0);

    // Misaligned half: error response, memory untouched.
    issue(0, BASE, 0, 1, 1, 2'b01, BASE + 32'h23, 32'h0000_BEEF);
    check("misaligned_untouched", sim_word(BASE + 32'h20), 32'h11AA_3344);

    // Reset during RMW_WR of a byte store.
    issue(0, BASE, 0, 1, 1, 2'b10, BASE + 32'h30, 32'h1122_3344);
    @(posedge clk); #1;
    bus.dm_req_i = 1'b1;
    bus.dm_we_i = 1'b1;
    bus.dm_size_i = 2'b00;
    bus.dm_addr_i = BASE + 32'h31;
    bus.dm_wdata_i = 32'h0000_0055;
    @(negedge clk);
    check("abort_gnt", bus.dm_gnt_o, 1'b1);
    @(posedge clk); #1;
    bus.dm_req_i = 1'b0;
    @(posedge clk); #1;
    check("abort_wr_phase", bus.mem_write_en_o, 1'b1);
    rst = 1'b1;
    #1;
    check_outputs_idle("abort");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_word_kept", sim_word(BASE + 32'h30), 32'h1122_3344);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_rvalid", bus.dm_rvalid_o, 1'b0);
    end
    ref_last = PORT_IF;
    ref_busy = 0;

    // Random traffic against the model.
    for (int n = 0; n < 150; n++) begin
      int          mode;
      logic [31:0] ia, da, wd;
      mode = $urandom_range(0, 2);
      ia = BASE | 32'($urandom_range(0, 255));
      da = BASE | 32'($urandom_range(0, 255));
      wd = $urandom;
      issue(mode != 1, ia, (mode == 2) ? $urandom_range(0, 3) : 0,
            mode != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), da, wd);
    end

    for (int w = 0; w < 64; w++) begin
      check("final_mem", sim_word(BASE + 32'(w * 4)), ref_read(BASE + 32'(w * 4)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the single-ported, byte-addressable `memory` instance. It lets the instruction-fetch stage and the load/store stage share one memory:
- Round-robin arbitration when both request.
- Registered read responses.
- Byte and halfword stores done as a two-cycle read-modify-write, because the memory only writes full 32-bit words.

It sits between the core pipeline and `memory`, and drives `addr_i`, `data_i`, `read_en_i` and `write_en_i` of the memory directly.

## Interface
- `AWIDTH`, 32, address width (matches memory)
- `DWIDTH`, 32, data width; fixed at 32, lane logic assumes 4 bytes
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `if_req_i`  in  1  fetch request; held until `if_gnt_o`
- `if_addr_i`  in  AWIDTH  fetch address
- `if_gnt_o`  out  1  fetch request accepted this cycle
- `if_rvalid_o`  out  1  fetch data valid (one-cycle pulse)
- `if_rdata_o`  out  DWIDTH  fetch read data
- `dm_req_i`  in  1  data request; held with stable fields until `dm_gnt_o`
- `dm_we_i`  in  1  1 = store, 0 = load
- `dm_size_i`  in  2  00 byte, 01 half, 10 word; 11 is illegal
- `dm_addr_i`  in  AWIDTH  data address
- `dm_wdata_i`  in  DWIDTH  store data, right-justified
- `dm_gnt_o`  out  1  data request accepted this cycle
- `dm_rvalid_o`  out  1  load data or store completion valid (one-cycle pulse)
- `dm_rdata_o`  out  DWIDTH  load data; 0 for stores
- `dm_err_o`  out  1  qualifies `dm_rvalid_o`; the access was misaligned or illegal and was not performed
- `mem_addr_o`  out  AWIDTH  to memory `addr_i`
- `mem_wdata_o`  out  DWIDTH  to memory `data_i`
- `mem_read_en_o`  out  1  to memory `read_en_i`
- `mem_write_en_o`  out  1  to memory `write_en_i`
- `mem_rdata_i`  in  DWIDTH  from memory `data_o` (combinational read)

## Operation
- FSM states: `IDLE`, `RMW_RD`, `RMW_WR`. Reset puts the FSM in `IDLE`.
- **Grants.** Grants are issued only in `IDLE`, and at most one per cycle. Both grants are forced to 0 while `rst` is high.
- **Arbitration.**
  - With one request, that requester wins.
  - With both requesting, the winner is the port *not* granted last. The 1-bit `last_gnt` register resets to "fetch", so data wins the first tie.
  - `last_gnt` updates on every grant.
- **Fetch, or data load.** In the grant cycle, drive `mem_addr_o` = request address and `mem_read_en_o` = 1, then register `mem_rdata_i`. The winner's `rvalid` and `rdata` are asserted in the next cycle. Loads return the full word at the given address; sign and zero extension belong to the core. The FSM stays in `IDLE`.
- **Word store.** In the grant cycle, drive `mem_write_en_o` = 1, `mem_addr_o` = `dm_addr_i` and `mem_wdata_o` = `dm_wdata_i`. `dm_rvalid_o` is asserted next cycle with `dm_rdata_o` = 0. The FSM stays in `IDLE`.
- **Byte or half store.**
  - On grant, latch the aligned address (`addr & ~3`), the lane (`addr[1:0]`), the size and the data, then go to `RMW_RD`.
  - `RMW_RD`: read the aligned word, register the merged word (the selected byte or half replaced, other lanes kept), go to `RMW_WR`.
  - `RMW_WR`: write the merged word to the aligned address, go to `IDLE`, and pulse `dm_rvalid_o` next cycle.
- **Misaligned or illegal data access.** This covers a half at lane 3, and size 11. It is granted, no memory enable is driven, and `dm_rvalid_o` and `dm_err_o` are asserted next cycle. Unaligned words are legal because the memory supports them.
- **Idle bus.** When there is no access, `mem_read_en_o`, `mem_write_en_o`, `mem_addr_o` and `mem_wdata_o` are all 0.

## Timing
- Reset values: all `*_gnt_o`, `*_rvalid_o` and `dm_err_o` are 0; `*_rdata_o` is 0; memory enables are 0.
- Reads and word stores: grant at T, response at T+1. A new grant is possible at T+1, giving back-to-back throughput of 1 per cycle.
- Sub-word stores: grant at T, `RMW_RD` at T+1, `RMW_WR` at T+2, `dm_rvalid_o` at T+3.
  - No grants at T+1 or T+2.
  - The next grant is possible at T+3.
- Asynchronous reset mid-RMW:
  - The FSM returns to `IDLE` immediately and `mem_write_en_o` drops combinationally, so no partial write happens.
  - No response is issued for the aborted request.
- A read of the word an RMW is writing at T+2, granted at T+3, returns the merged value.

## Structure
- Package `mem_arb_pkg` holds:
  - `size_e` (`SZ_BYTE`=2'b00, `SZ_HALF`=2'b01, `SZ_WORD`=2'b10)
  - `state_e` (`IDLE`, `RMW_RD`, `RMW_WR`)
  - the port-select encoding (`PORT_IF`=0, `PORT_DM`=1)
- One sub-module, `mem_arb_merge`: purely combinational lane merge. Inputs are the old word, the new data, the lane and the size; output is the merged word. It is unit-testable on its own.
- The FSM, arbiter and response registers live in `mem_arbiter`.

## Test plan
- Reset, then a fetch at 0x01000000 alone → `if_gnt_o` the same cycle; `if_rvalid_o` next cycle with the loaded word, e.g. 0x00000013.
- Both requesting in `IDLE` for 4 consecutive accepts after reset → grant order DM, IF, DM, IF.
- Word store of 0xDEADBEEF at 0x01000010, then a load at 0x01000010 → ack at T+1 with `dm_rdata_o` = 0; the load returns 0xDEADBEEF.
- Word 0x11223344 at 0x01000020, then a byte store of 0xAA at 0x01000022, then a load → ack at T+3; the load returns 0x11AA3344. A fetch request raised at T+1 is granted no earlier than T+3.
- Half store at 0x01000023 → no memory enable; `dm_rvalid_o` and `dm_err_o` at T+1; the memory word is unchanged.
- Assert `rst` during `RMW_WR` of a byte store to a word holding 0x11223344 → no write, no `dm_rvalid_o`, the word stays 0x11223344, and all outputs are at their reset values.
